// File: rtl/imem_ctrl.sv
// Instruction memory controller: single-cycle fetch port, program-write port and a full-array CLEAR sweep.
// Optional macro IMEM_PARITY_EN adds a per-word even-parity bit and the prog_par_inv_i error-injection input.
module imem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              SYS_clk_i,
  input  logic              SYS_reset_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_instr_o,
  output logic              resp_err_o,
  output logic [1:0]        resp_err_code_o,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
`ifdef IMEM_PARITY_EN
  input  logic              prog_par_inv_i,
`endif
  output logic              prog_ack_o,
  input  logic              clear_req_i,
  output logic              busy_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic              fetch_ready_q, busy_q, resp_valid_q, resp_err_q, prog_ack_q;
  logic [DATA_W-1:0] resp_instr_q;
  logic [1:0]        resp_code_q;

  logic [MW-1:0]     mem_q [DEPTH];

  logic [ADDR_W-3:0] f_widx, p_widx;
  logic              f_mis, f_oor, f_par, p_ok;
  logic [MW-1:0]     rd_word, wr_word;

  assign f_widx  = fetch_addr_i[ADDR_W-1:2];
  assign p_widx  = prog_addr_i[ADDR_W-1:2];
  assign f_mis   = |fetch_addr_i[1:0];
  assign f_oor   = f_widx >= (ADDR_W-2)'(DEPTH);
  assign p_ok    = ~(|prog_addr_i[1:0]) && (p_widx < (ADDR_W-2)'(DEPTH));
  // Combinational read sees the pre-edge contents, giving read-before-write on collisions.
  assign rd_word = mem_q[f_widx[IW-1:0]];

`ifdef IMEM_PARITY_EN
  assign wr_word = {(^prog_data_i) ^ prog_par_inv_i, prog_data_i};
  assign f_par   = (^rd_word[DATA_W-1:0]) != rd_word[DATA_W];
`else
  assign wr_word = prog_data_i;
  assign f_par   = 1'b0;
`endif

  // Storage has no reset; only the sweep zeroes it.
  always_ff @(posedge SYS_clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem_q[idx_q] <= '0;
    end else if (prog_we_i && p_ok) begin
      mem_q[p_widx[IW-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge SYS_clk_i or posedge SYS_reset_i) begin
    if (SYS_reset_i) begin
      state_q       <= ST_CLEAR;
      idx_q         <= '0;
      fetch_ready_q <= 1'b0;
      busy_q        <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_instr_q  <= '0;
      resp_err_q    <= 1'b0;
      resp_code_q   <= 2'b00;
      prog_ack_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      prog_ack_q   <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(DEPTH - 1)) begin
            state_q       <= ST_READY;
            idx_q         <= '0;
            fetch_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        ST_READY: begin
          if (fetch_req_i) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= f_mis || f_oor || f_par;
            resp_instr_q <= '0;
            if (f_mis)      resp_code_q <= 2'b01;
            else if (f_oor) resp_code_q <= 2'b10;
            else if (f_par) resp_code_q <= 2'b11;
            else begin
              resp_code_q  <= 2'b00;
              resp_instr_q <= rd_word[DATA_W-1:0];
            end
          end
          if (prog_we_i) prog_ack_q <= 1'b1;
          if (clear_req_i) begin
            state_q       <= ST_CLEAR;
            idx_q         <= '0;
            fetch_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
      endcase
    end
  end

  assign fetch_ready_o   = fetch_ready_q;
  assign busy_o          = busy_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_instr_o    = resp_instr_q;
  assign resp_err_o      = resp_err_q;
  assign resp_err_code_o = resp_code_q;
  assign prog_ack_o      = prog_ack_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl (DEPTH=16): response scoreboard plus a small reference model of the array.
module tb_imem_ctrl;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } resp_t;

`ifdef IMEM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, prog_we, clear_req, prog_par_inv;
  logic [31:0] fetch_addr, prog_addr, prog_data;
  logic        fetch_ready, resp_valid, resp_err, prog_ack, busy;
  logic [31:0] resp_instr;
  logic [1:0]  resp_code;

  int n_cmp = 0;
  int n_bad = 0;
  resp_t exp_q[$];
  logic [31:0] model [16];
  bit          par_bad [16];

  imem_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
    .SYS_clk_i(clk),
    .SYS_reset_i(rst),
    .fetch_req_i(fetch_req),
    .fetch_addr_i(fetch_addr),
    .fetch_ready_o(fetch_ready),
    .resp_valid_o(resp_valid),
    .resp_instr_o(resp_instr),
    .resp_err_o(resp_err),
    .resp_err_code_o(resp_code),
    .prog_we_i(prog_we),
    .prog_addr_i(prog_addr),
    .prog_data_i(prog_data),
`ifdef IMEM_PARITY_EN
    .prog_par_inv_i(prog_par_inv),
`endif
    .prog_ack_o(prog_ack),
    .clear_req_i(clear_req),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic resp_t exp_resp(input logic [31:0] a);
    resp_t r;
    r = '0;
    if (a[1:0] != 2'b00) begin
      r.err = 1'b1; r.code = 2'b01;
    end else if ((a >> 2) >= 32'd16) begin
      r.err = 1'b1; r.code = 2'b10;
    end else if (PAR_EN && par_bad[a[5:2]]) begin
      r.err = 1'b1; r.code = 2'b11;
    end else begin
      r.instr = model[a[5:2]];
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input bit inv);
    if (a[1:0] == 2'b00 && (a >> 2) < 32'd16) begin
      model[a[5:2]]   = d;
      par_bad[a[5:2]] = inv;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      model[i]   = '0;
      par_bad[i] = 1'b0;
    end
  endfunction

  // Scoreboard: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'(0));
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp", 64'({resp_instr, resp_err, resp_code}), 64'(e));
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    exp_q.push_back(exp_resp(a));
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input bit inv);
    prog_we      = 1'b1;
    prog_addr    = a;
    prog_data    = d;
    prog_par_inv = inv;
    @(negedge clk);
    prog_we      = 1'b0;
    prog_par_inv = 1'b0;
    check("prog_ack", 64'(prog_ack), 64'(1));
    model_write(a, d, inv);
  endtask

  task automatic measure_busy(input bit quiet, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (quiet) begin
        check("quiet_valid", 64'(resp_valid), 64'(0));
        check("quiet_ack", 64'(prog_ack), 64'(0));
      end
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    fetch_req = 1'b0; prog_we = 1'b0; clear_req = 1'b0; prog_par_inv = 1'b0;
    fetch_addr = '0; prog_addr = '0; prog_data = '0;
    model_clear();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(1));
    check("rst_ready", 64'(fetch_ready), 64'(0));
    check("rst_valid", 64'(resp_valid), 64'(0));
    check("rst_instr", 64'(resp_instr), 64'(0));
    check("rst_err", 64'(resp_err), 64'(0));
    check("rst_code", 64'(resp_code), 64'(0));
    check("rst_ack", 64'(prog_ack), 64'(0));

    @(negedge clk);
    rst = 1'b0;
    measure_busy(1'b1, n);
    check("init_busy_cycles", 64'(n), 64'(16));
    check("init_ready", 64'(fetch_ready), 64'(1));

    fetch(32'h20);
    write(32'h08, 32'h0050_0093, 1'b0);
    fetch(32'h08);
    fetch(32'h06);
    fetch(32'h40);
    fetch(32'h42);
    @(negedge clk);
    check("hold_valid", 64'(resp_valid), 64'(0));
    check("hold_resp", 64'({resp_instr, resp_err, resp_code}), 64'({32'h0, 1'b1, 2'b01}));

    write(32'h0C, 32'h1111_1111, 1'b0);
    fetch_req = 1'b1; fetch_addr = 32'h0C;
    exp_q.push_back(exp_resp(32'h0C));
    write(32'h0C, 32'hDEAD_BEEF, 1'b0);
    fetch_req = 1'b0;
    fetch(32'h0C);

    write(32'h0E, 32'hFFFF_FFFF, 1'b0);
    write(32'h80, 32'hFFFF_FFFF, 1'b0);
    fetch(32'h0C);
    fetch(32'h3C);

    write(32'h04, 32'h1234_5678, 1'b1);
    fetch(32'h04);
    fetch(32'h10);

    // Clear sweep with fetch, write and clear_req all held active throughout.
    clear_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h08;
    prog_we = 1'b1; prog_addr = 32'h10; prog_data = 32'hAAAA_5555;
    model_clear();
    measure_busy(1'b1, n);
    fetch_req = 1'b0; prog_we = 1'b0; clear_req = 1'b0;
    check("clear_busy_cycles", 64'(n), 64'(16));
    fetch(32'h08);
    fetch(32'h10);

    // Reset pulse after sweep index 5 restarts the full sweep.
    write(32'h3C, 32'hCAFE_F00D, 1'b0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(1));
    check("midrst_ready", 64'(fetch_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    measure_busy(1'b1, n);
    check("midrst_busy_cycles", 64'(n), 64'(16));
    fetch(32'h3C);

    // Fetch and write accepted together with clear_req complete before the sweep.
    write(32'h14, 32'h0BAD_CAFE, 1'b0);
    fetch_req = 1'b1; fetch_addr = 32'h14;
    exp_q.push_back(exp_resp(32'h14));
    clear_req = 1'b1;
    write(32'h18, 32'h0000_0077, 1'b0);
    fetch_req = 1'b0; clear_req = 1'b0;
    check("clr_same_busy", 64'(busy), 64'(1));
    model_clear();
    measure_busy(1'b0, n);
    check("clr_same_busy_cycles", 64'(n), 64'(16));
    fetch(32'h18);

    repeat (3) @(negedge clk);
    check("pending_resp", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
